noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Router-side receiver for one inter-node link; sits directly downstream of the `node_port` link and terminates its `down` modport.
- Accepts flits from the upstream node and stores them in a DEPTH-entry circular FIFO.
- Drives `ack` as registered backpressure.
- Presents the head flit to the router's route/crossbar stage over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of flit slots; power of two, minimum 2.
- AF_LEVEL, DEPTH-1, occupancy at or above which `almost_full` asserts.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- link  node_port.down  interface  upstream link: `link.flit` (flit_t) in, `link.enable` in, `link.ack` out.
- out_flit  output  $bits(flit_t)  head-of-FIFO flit.
- out_valid  output  1  `out_flit` holds a valid flit.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- almost_full  output  1  count >= AF_LEVEL.

Behaviour:
- Reset and clocking:
  - Reset is asynchronous assert, synchronous deassert, handled externally.
  - While rst_n=0: wr_ptr=0, rd_ptr=0, count=0, link.ack=0, out_valid=0, almost_full=0.
  - Storage contents are don't-care after reset.
- Link handshake:
  - Upstream holds `flit` stable with `enable`=1 until it samples ack=1.
  - A push occurs on a rising edge where link.enable=1 and link.ack=1.
  - link.ack = (count != DEPTH). It is decoded from registered state only; no combinational path from enable or out_ready.
  - link.ack=0 during reset and returns to 1 the first cycle after reset is released (buffer empty).
- Output handshake:
  - A pop occurs on a rising edge where out_valid=1 and out_ready=1.
  - out_valid = (count != 0).
  - out_flit = mem[rd_ptr] (first-word fall-through).
  - out_flit is don't-care when out_valid=0.
- Latency: a flit pushed at edge N is visible on out_flit/out_valid after edge N (earliest pop at edge N+1). Minimum link-to-output latency is 1 cycle.
- Ordering: strict FIFO; no reordering, no drops, no duplication.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full/empty is determined by count, not by pointer compare.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
  - neither: unchanged.
- Boundary conditions:
  - Full (count=DEPTH): ack=0, so no push even if a pop happens the same cycle. Ack reasserts the cycle after the pop.
  - Empty (count=0): out_valid=0; out_ready is ignored. A simultaneous push makes the flit visible next cycle (no bypass).
  - enable=1 while ack=0: the flit is not written and upstream must hold it. The buffer never records a flit without ack=1.
  - Reset mid-operation: all buffered flits are discarded; count and pointers go to 0 immediately (async).
- almost_full is registered-equivalent: decoded from count only.
- Assertions (verification-only):
  - count never exceeds DEPTH and never underflows.
  - No push while count=DEPTH.
  - link.flit is stable while enable=1 and ack=0 (upstream protocol check).

Test Plan (DEPTH=4, AF_LEVEL=3):
- Reset then idle → ack=1, out_valid=0, count=0 one cycle after rst_n rises. During rst_n=0: ack=0 and out_valid=0.
- Push flits A,B,C,D back-to-back with out_ready=0 → count goes 1,2,3,4; almost_full=1 at count 3; ack=0 after the 4th push. A 5th flit E held with enable=1 is not accepted and count stays 4.
- From full, out_ready=1 for one cycle → A popped, count=3. Ack=1 the next cycle, E accepted on the following edge, count=4. Subsequent drain order is B,C,D,E.
- Continuous enable=1 and out_ready=1 from empty, 10 flits (values 0..9) → first pop one cycle after the first push. Thereafter one flit per cycle, count stable at 1, output order 0..9, pointers wrap twice.
- Empty buffer with out_ready=1 and a single push of 0x5A → out_valid=0 in the push cycle; out_flit=0x5A, out_valid=1 next cycle; popped that cycle; count returns to 0.
- Fill to 3, assert rst_n=0 mid-cycle → count=0, out_valid=0, ack=0 immediately (no clock edge needed). After release, a fresh push of 0x11 emerges first with no stale data.

Source files
------------

// File: rtl/noc_input_buffer_if.sv
// Flit type shared by both ends of an inter-node link, and the link interface itself.
// The upstream node drives the "up" side; the router input buffer terminates the "down" side.
package noc_pkg;
   typedef logic [7:0] flit_t;
endpackage

interface node_port;
   import noc_pkg::*;

   flit_t flit;
   logic  enable;
   logic  ack;

   modport up   (output flit, output enable, input ack);
   modport down (input flit, input enable, output ack);
endinterface

// File: rtl/noc_input_buffer.sv
// Router-side input buffer for one link: circular FIFO with registered ack backpressure
// and a first-word fall-through valid/ready output towards the route/crossbar stage.
module noc_input_buffer
   import noc_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   node_port.down                     link,
   output flit_t                      out_flit,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

   flit_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          ack_q;
   logic          push;
   logic          pop;

   assign push = link.enable & ack_q;
   assign pop  = out_valid & out_ready;

   always_comb begin
      count_next = count_q;
      case ({push, pop})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
   end

   // Ack is a flop loaded from next-state occupancy so it stays low through reset
   // and never depends combinationally on enable or out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count_q <= count_next;
         ack_q   <= (count_next != FULL_COUNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= link.flit;
   end

   assign link.ack    = ack_q;
   assign out_flit    = mem[rd_ptr];
   assign out_valid   = (count_q != '0);
   assign count       = count_q;
   assign almost_full = (count_q >= AF_COUNT);

   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= FULL_COUNT);
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && count_q == '0));
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && count_q == FULL_COUNT));
   a_flit_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (link.enable && !link.ack) |=> $stable(link.flit));

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_noc_input_buffer;
   import noc_pkg::*;

   localparam int DEPTH    = 4;
   localparam int AF_LEVEL = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   flit_t      out_flit;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count;
   logic       almost_full;

   node_port link();

   noc_input_buffer #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .link        (link),
      .out_flit    (out_flit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   flit_t model_q[$];
   logic  model_ack;
   flit_t last_pop;
   logic  accepted;

   typedef struct {
      logic  en;
      flit_t flit;
      logic  rdy;
      int    exp_count;
      logic  exp_valid;
      logic  exp_ack;
      logic  exp_af;
      flit_t exp_flit;
   } vec_t;

   vec_t vecs[11];

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock once, then advance the reference model.
   task automatic apply_stimulus(input logic en, input flit_t f, input logic rdy);
      logic push_m;
      logic pop_m;
      link.enable = en;
      link.flit   = f;
      out_ready   = rdy;
      accepted    = en && (link.ack === 1'b1);
      push_m      = en && model_ack;
      pop_m       = rdy && (model_q.size() != 0);
      @(posedge clk);
      #1;
      if (pop_m)  last_pop = model_q.pop_front();
      if (push_m) model_q.push_back(f);
      model_ack = (model_q.size() != DEPTH);
   endtask

   task automatic check_output(input string tag);
      check_val({tag, " count"}, 32'(count), 32'(model_q.size()));
      check_val({tag, " out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
      check_val({tag, " ack"}, 32'(link.ack), 32'(model_ack));
      check_val({tag, " almost_full"}, 32'(almost_full), 32'(model_q.size() >= AF_LEVEL));
      if (model_q.size() != 0)
         check_val({tag, " out_flit"}, 32'(out_flit), 32'(model_q[0]));
   endtask

   task automatic check_const(input string tag, input int c, input logic v, input logic a, input logic af);
      check_val({tag, " count"}, 32'(count), 32'(c));
      check_val({tag, " out_valid"}, 32'(out_valid), 32'(v));
      check_val({tag, " ack"}, 32'(link.ack), 32'(a));
      check_val({tag, " almost_full"}, 32'(almost_full), 32'(af));
   endtask

   initial begin
      logic  pending;
      flit_t pend_f;
      logic  en;
      flit_t f;
      logic  rdy;
      int    thresh;

      // Fill A..D, hold E against backpressure, pop once, accept E, then drain.
      vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'hA1};
      vecs[1]  = '{1'b1, 8'hB2, 1'b0, 2, 1'b1, 1'b1, 1'b0, 8'hA1};
      vecs[2]  = '{1'b1, 8'hC3, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'hA1};
      vecs[3]  = '{1'b1, 8'hD4, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'hA1};
      vecs[4]  = '{1'b1, 8'hE5, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'hA1};
      vecs[5]  = '{1'b1, 8'hE5, 1'b1, 3, 1'b1, 1'b1, 1'b1, 8'hB2};
      vecs[6]  = '{1'b1, 8'hE5, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'hB2};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 1'b1, 8'hC3};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 1'b0, 8'hD4};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'hE5};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00};

      rst_n       = 1'b0;
      link.enable = 1'b0;
      link.flit   = '0;
      out_ready   = 1'b0;
      model_ack   = 1'b0;
      last_pop    = '0;
      accepted    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_const("in_reset", 0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      check_val("ack_before_first_edge", 32'(link.ack), 32'd0);
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_const("after_reset", 0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 11; i++) begin
         apply_stimulus(vecs[i].en, vecs[i].flit, vecs[i].rdy);
         check_const($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                     vecs[i].exp_ack, vecs[i].exp_af);
         if (vecs[i].exp_valid)
            check_val($sformatf("vec%0d out_flit", i), 32'(out_flit), 32'(vecs[i].exp_flit));
      end

      // Streaming through: one flit per cycle, occupancy stays at one, pointers wrap.
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, flit_t'(i), 1'b1);
         check_val($sformatf("pipe%0d count", i), 32'(count), 32'd1);
         check_val($sformatf("pipe%0d out_valid", i), 32'(out_valid), 32'd1);
         check_val($sformatf("pipe%0d out_flit", i), 32'(out_flit), 32'(i));
      end
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_const("pipe_drained", 0, 1'b0, 1'b1, 1'b0);

      // Push into an empty buffer with out_ready high: no same-cycle bypass.
      check_val("nobypass pre out_valid", 32'(out_valid), 32'd0);
      apply_stimulus(1'b1, 8'h5A, 1'b1);
      check_const("nobypass visible", 1, 1'b1, 1'b1, 1'b0);
      check_val("nobypass out_flit", 32'(out_flit), 32'h5A);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_const("nobypass popped", 0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset with three flits buffered, then fresh data only.
      apply_stimulus(1'b1, 8'h31, 1'b0);
      apply_stimulus(1'b1, 8'h32, 1'b0);
      apply_stimulus(1'b1, 8'h33, 1'b0);
      check_const("prefill", 3, 1'b1, 1'b1, 1'b1);
      #2;
      link.enable = 1'b0;
      rst_n       = 1'b0;
      #1;
      check_const("async_reset", 0, 1'b0, 1'b0, 1'b0);
      model_q.delete();
      model_ack = 1'b0;
      @(posedge clk);
      #1;
      check_const("reset_held", 0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 8'h00, 1'b0);
      check_const("reset_release", 0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1'b1, 8'h11, 1'b0);
      check_const("fresh_push", 1, 1'b1, 1'b1, 1'b0);
      check_val("fresh out_flit", 32'(out_flit), 32'h11);
      apply_stimulus(1'b0, 8'h00, 1'b1);
      check_const("fresh_popped", 0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic; consumer speed alternates so the buffer hits full and empty.
      pending = 1'b0;
      pend_f  = '0;
      for (int c = 0; c < 400; c++) begin
         if (pending) begin
            en = 1'b1;
            f  = pend_f;
         end else begin
            en = 1'($urandom_range(0, 1));
            f  = flit_t'($urandom);
         end
         thresh = ((c / 50) % 2 == 1) ? 8 : 2;
         rdy    = ($urandom_range(0, 9) < thresh);
         apply_stimulus(en, f, rdy);
         pending = en && !accepted;
         pend_f  = f;
         check_output($sformatf("rand%0d", c));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
